debug_slave_jtag_host: RTL and testbench

Cycle-driven JTAG host that sits on the system-clock side and drives the virtual-JTAG signal set (tck, tdi, ir_in, cdr/sdr/udr/uir/rti) of the CPU debug slave in simulation and in test harnesses. It accepts one command at a time, consisting of a 2-bit IR value and a 38-bit data word. For each command it plays a complete UIR → CDR → SDR(×38) → UDR → RTI sequence on a divided tck, captures the 38 tdo bits, and returns them on a response handshake. It is the initiator end of the interface that the debug slave responds to.

---
 rtl/debug_slave_jtag_host.sv | 119 +++++++++++
 tb/tb_debug_slave_jtag_host.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_slave_jtag_host.sv
// Cycle-driven virtual-JTAG host: plays UIR/CDR/SDR/UDR/RTI for one command on a
// divided tck and returns the captured tdo word through a valid/ready response.
module debug_slave_jtag_host #(
  parameter int TCK_HALF   = 2,
  parameter int DR_WIDTH   = 38,
  parameter int RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                busy,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_uir,
  output logic                vji_rti,
  output logic [1:0]          vji_ir_in,
  input  logic                vji_tdo
);

  localparam int CW   = $clog2(2 * TCK_HALF);
  localparam int BMAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
  localparam int BW   = $clog2(BMAX + 1);
  localparam logic [CW-1:0] RISE_CNT = CW'(TCK_HALF - 1);
  localparam logic [CW-1:0] FALL_CNT = CW'(2 * TCK_HALF - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DR_WIDTH - 1);
  localparam logic [BW-1:0] LAST_RTI = BW'(RTI_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RSP
  } state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg;
  logic [BW-1:0]       bit_cnt_reg;
  logic                tck_reg;
  logic [1:0]          ir_reg;
  logic [DR_WIDTH-1:0] shift_reg;
  logic [DR_WIDTH-1:0] rsp_reg;

  logic active, accept, tck_fall, tck_rise;

  assign active   = (state_reg != S_IDLE) && (state_reg != S_RSP);
  assign accept   = cmd_valid && cmd_ready;
  // The edge that lowers tck closes the current tck cycle and opens the next one.
  assign tck_fall = active && (cnt_reg == FALL_CNT);
  assign tck_rise = active && (cnt_reg == RISE_CNT);

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: if (accept) state_next = S_UIR;
      S_UIR:  if (tck_fall) state_next = S_CDR;
      S_CDR:  if (tck_fall) state_next = S_SDR;
      S_SDR:  if (tck_fall && (bit_cnt_reg == LAST_BIT)) state_next = S_UDR;
      S_UDR:  if (tck_fall) state_next = S_RTI;
      S_RTI:  if (tck_fall && (bit_cnt_reg == LAST_RTI)) state_next = S_RSP;
      S_RSP:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      tck_reg     <= 1'b0;
      ir_reg      <= 2'b00;
      shift_reg   <= '0;
      rsp_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        ir_reg      <= cmd_ir;
        shift_reg   <= cmd_data;
        cnt_reg     <= '0;
        bit_cnt_reg <= '0;
        tck_reg     <= 1'b0;
      end else if (active) begin
        if (tck_fall) begin
          cnt_reg     <= '0;
          tck_reg     <= 1'b0;
          bit_cnt_reg <= (state_next == state_reg) ? bit_cnt_reg + BW'(1) : '0;
          // Shift on the falling edge so tdi never moves while tck is high.
          if (state_reg == S_SDR) shift_reg <= shift_reg >> 1;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
          if (tck_rise) begin
            tck_reg <= 1'b1;
            if (state_reg == S_SDR) rsp_reg <= {vji_tdo, rsp_reg[DR_WIDTH-1:1]};
          end
        end
      end
    end
  end

  assign cmd_ready = (state_reg == S_IDLE) && !reset;
  assign rsp_valid = (state_reg == S_RSP);
  assign rsp_data  = rsp_reg;
  assign busy      = active;
  assign vji_tck   = tck_reg;
  assign vji_ir_in = ir_reg;
  assign vji_uir   = (state_reg == S_UIR);
  assign vji_cdr   = (state_reg == S_CDR);
  assign vji_sdr   = (state_reg == S_SDR);
  assign vji_udr   = (state_reg == S_UDR);
  assign vji_rti   = (state_reg == S_RTI);
  assign vji_tdi   = (state_reg == S_SDR) && shift_reg[0];

endmodule

// File: tb/tb_debug_slave_jtag_host.sv
// Bench for debug_slave_jtag_host: default instance talks to a 1-bit-delay echo
// slave; a second fast instance (TCK_HALF=1, RTI_CYCLES=1) has tdo tied high.
module tb_debug_slave_jtag_host;
  localparam int H   = 2;
  localparam int W   = 38;
  localparam int RTI = 2;
  localparam int N   = W + 3 + RTI;
  localparam int LAT = 2 * H * N + 1;
  localparam int FN  = W + 3 + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0, busy;
  logic [1:0]   cmd_ir = 2'b00, vji_ir_in;
  logic [W-1:0] cmd_data = '0, rsp_data;
  logic vji_tck, vji_tdi, vji_cdr, vji_sdr, vji_udr, vji_uir, vji_rti, vji_tdo;

  debug_slave_jtag_host #(.TCK_HALF(H), .DR_WIDTH(W), .RTI_CYCLES(RTI)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy), .vji_tck(vji_tck), .vji_tdi(vji_tdi),
    .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_uir(vji_uir),
    .vji_rti(vji_rti), .vji_ir_in(vji_ir_in), .vji_tdo(vji_tdo));

  logic         f_cmd_valid = 1'b0, f_cmd_ready, f_rsp_valid, f_rsp_ready = 1'b0, f_busy;
  logic [1:0]   f_cmd_ir = 2'b10, f_ir_in;
  logic [W-1:0] f_cmd_data = '0, f_rsp_data;
  logic f_tck, f_tdi, f_cdr, f_sdr, f_udr, f_uir, f_rti;

  debug_slave_jtag_host #(.TCK_HALF(1), .DR_WIDTH(W), .RTI_CYCLES(1)) dut_fast (
    .clk(clk), .reset(reset), .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready),
    .cmd_ir(f_cmd_ir), .cmd_data(f_cmd_data), .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready),
    .rsp_data(f_rsp_data), .busy(f_busy), .vji_tck(f_tck), .vji_tdi(f_tdi),
    .vji_cdr(f_cdr), .vji_sdr(f_sdr), .vji_udr(f_udr), .vji_uir(f_uir),
    .vji_rti(f_rti), .vji_ir_in(f_ir_in), .vji_tdo(1'b1));

  int errors = 0;
  int checks = 0;

  // Slave model: tdo presents the tdi seen at the previous tck rising edge.
  logic tdo_q = 1'b0;
  assign vji_tdo = tdo_q;
  int tck_rises = 0;
  bit tdi_q[$];
  always @(posedge vji_tck) begin
    tck_rises++;
    if (vji_sdr) tdi_q.push_back(vji_tdi);
    tdo_q <= vji_tdi;
  end

  // Protocol monitor: strobes/tdi frozen while tck high, tdi only in SDR, IR moves only at accept.
  logic acc_seen = 1'b0, rst_seen = 1'b1;
  logic [5:0] prev_s = '0, cur_s;
  logic [1:0] prev_ir = '0;
  int strobe_bad = 0, ir_bad = 0;
  always @(posedge clk) begin
    acc_seen <= cmd_valid && cmd_ready;
    rst_seen <= reset;
  end
  always @(negedge clk) begin
    cur_s = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdi};
    if (!reset && !rst_seen) begin
      if (vji_tck && cur_s != prev_s) strobe_bad++;
      if (vji_tdi && !vji_sdr) strobe_bad++;
      if (vji_ir_in != prev_ir && !acc_seen) ir_bad++;
    end
    prev_s  = cur_s;
    prev_ir = vji_ir_in;
  end

  int start_rises;

  task automatic accept_cmd(input logic [1:0] ir, input logic [W-1:0] d, output bit ok);
    @(negedge clk);
    cmd_ir = ir; cmd_data = d; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    tdi_q.delete();
    start_rises = tck_rises;
    if (ok) @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [W-1:0] d, output int cyc, output bit ok);
    cyc = 1; ok = 1'b0; d = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
      cyc++;
    end
    if (ok) begin
      d = rsp_data; rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    checks++;
    if ({busy, rsp_valid, vji_tck, cur_s} !== 9'd0) begin
      errors++; $display("FAIL reset_outputs: got %b want 0", {busy, rsp_valid, vji_tck, cur_s});
    end
    checks++;
    if (rsp_data !== '0 || vji_ir_in !== 2'b00) begin
      errors++; $display("FAIL reset_data_ir: got %h/%b want 0/00", rsp_data, vji_ir_in);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic run_and_check(input string name, input logic [1:0] ir, input logic [W-1:0] d);
    bit ok; int cyc; logic [W-1:0] got; logic [W-1:0] exp_v; logic [W-1:0] got_tdi;
    exp_v = d << 1;
    accept_cmd(ir, d, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_accept: got no accept want accept", name); return; end
    wait_rsp(got, cyc, ok);
    checks++;
    if (!ok || cyc != LAT) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, ok ? cyc : -1, LAT); end
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL %s_rsp: got %h want %h", name, got, exp_v); end
    checks++;
    if (tck_rises - start_rises != N) begin errors++; $display("FAIL %s_tck_rises: got %0d want %0d", name, tck_rises - start_rises, N); end
    got_tdi = '0;
    foreach (tdi_q[i]) if (i < W) got_tdi[i] = tdi_q[i];
    checks++;
    if (tdi_q.size() != W || got_tdi !== d) begin
      errors++; $display("FAIL %s_tdi: got %0d bits %h want %0d bits %h", name, tdi_q.size(), got_tdi, W, d);
    end
    checks++;
    if (vji_ir_in !== ir) begin errors++; $display("FAIL %s_ir: got %b want %b", name, vji_ir_in, ir); end
    $display("txn %s ir=%b data=%h rsp=%h cyc=%0d", name, ir, d, got, cyc);
  endtask

  task automatic test_basic;
    run_and_check("basic", 2'b01, 38'h2A_5A5A_5A5A);
    for (int i = 0; i < 3; i++)
      run_and_check("random", 2'($urandom_range(0, 3)), W'({$urandom, $urandom}));
  endtask

  task automatic test_fast;
    int cyc, c_uir, c_cdr, c_sdr, c_udr, c_rti; bit ok;
    c_uir = 0; c_cdr = 0; c_sdr = 0; c_udr = 0; c_rti = 0; ok = 1'b0; cyc = 1;
    @(negedge clk);
    f_cmd_data = W'({$urandom, $urandom}); f_cmd_valid = 1'b1;
    checks++;
    if (f_cmd_ready !== 1'b1) begin errors++; $display("FAIL fast_ready: got %b want 1", f_cmd_ready); end
    @(posedge clk); #1 f_cmd_valid = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (f_rsp_valid) begin ok = 1'b1; break; end
      c_uir += int'(f_uir); c_cdr += int'(f_cdr); c_sdr += int'(f_sdr);
      c_udr += int'(f_udr); c_rti += int'(f_rti);
      cyc++;
    end
    checks++;
    if (!ok || cyc != 2 * FN + 1) begin errors++; $display("FAIL fast_latency: got %0d want %0d", ok ? cyc : -1, 2 * FN + 1); end
    checks++;
    if (f_rsp_data !== {W{1'b1}}) begin errors++; $display("FAIL fast_rsp: got %h want all ones", f_rsp_data); end
    checks++;
    if (c_uir != 2 || c_cdr != 2 || c_udr != 2 || c_rti != 2 || c_sdr != 2 * W) begin
      errors++;
      $display("FAIL fast_strobes: got uir=%0d cdr=%0d sdr=%0d udr=%0d rti=%0d want 2/2/%0d/2/2",
               c_uir, c_cdr, c_sdr, c_udr, c_rti, 2 * W);
    end
    f_rsp_ready = 1'b1; @(posedge clk); #1 f_rsp_ready = 1'b0;
    $display("txn fast data=%h rsp=%h cyc=%0d", f_cmd_data, f_rsp_data, cyc);
  endtask

  task automatic test_stall;
    bit ok; int cyc; logic [W-1:0] da, db, got; logic [1:0] irb;
    da = W'({$urandom, $urandom}); db = W'({$urandom, $urandom}); irb = 2'b10;
    accept_cmd(2'b11, da, ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_rsp_valid: got none want rsp_valid"); return; end
    cmd_ir = irb; cmd_data = db; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== (da << 1) || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b data=%h ready=%b want 1/%h/0", rsp_valid, rsp_data, cmd_ready, da << 1);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stall_idle: got ready=%b busy=%b want 1/0", cmd_ready, busy); end
    tdi_q.delete();
    @(posedge clk); #1 cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || vji_ir_in !== irb) begin errors++; $display("FAIL stall_accept: got busy=%b ir=%b want 1/%b", busy, vji_ir_in, irb); end
    wait_rsp(got, cyc, ok);
    checks++;
    if (!ok || got !== (db << 1)) begin errors++; $display("FAIL stall_second_rsp: got %h want %h", got, db << 1); end
    $display("txn stall a=%h b=%h rsp_b=%h", da, db, got);
  endtask

  task automatic test_reset_mid;
    bit ok; int seen_valid;
    accept_cmd(2'b01, W'({$urandom, $urandom}), ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tdi_q.size() == 10) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL midreset_reach_sdr: got %0d bits want 10", tdi_q.size()); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, rsp_valid, vji_tck, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdi} !== 9'd0 ||
        rsp_data !== '0 || vji_ir_in !== 2'b00 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: got busy=%b valid=%b tck=%b sdr=%b data=%h ir=%b ready=%b want all 0",
               busy, rsp_valid, vji_tck, vji_sdr, rsp_data, vji_ir_in, cmd_ready);
    end
    @(negedge clk); reset = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (rsp_valid) seen_valid++;
    end
    checks++;
    if (seen_valid != 0) begin errors++; $display("FAIL midreset_no_rsp: got %0d valid cycles want 0", seen_valid); end
    run_and_check("after_reset", 2'b10, W'({$urandom, $urandom}));
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++)
      run_and_check("b2b", 2'(i), W'({$urandom, $urandom}) ^ W'(i));
    checks++;
    if (ir_bad != 0) begin errors++; $display("FAIL ir_stability: got %0d changes outside accept want 0", ir_bad); end
  endtask

  task automatic test_strobes;
    checks++;
    if (strobe_bad != 0) begin errors++; $display("FAIL strobe_rules: got %0d violations want 0", strobe_bad); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_fast;
    test_stall;
    test_reset_mid;
    test_back_to_back;
    test_strobes;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
